// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl -- trap / interrupt sequencer for the kernel-mode flag register.
//
// Takes software traps and external interrupts while the core is in user
// mode (KF = flags_i[0] = 0). On entry it pulses to_kernel_o, captures the
// current flags and resume PC, then redirects fetch into the vector table.
// On return-from-trap it writes the saved flags back with KF cleared and
// redirects fetch to the saved PC. Every strobe is decoded from the
// registered state, so outputs change only on clock edges or on reset.
//
// Ports:
//   clk_i          clock
//   arst_i         asynchronous active-high reset
//   flags_i        current flag register value, bit 0 is KF
//   pc_i           PC to resume after the trap
//   irq_i          level interrupt requests, lowest index wins
//   irq_en_i       global interrupt enable
//   sw_trap_i      software trap request (held until redirect_o)
//   sw_trap_code_i software trap code
//   iret_i         return-from-trap request (held until redirect_o)
//   to_kernel_o    kernel-entry strobe to the flag register
//   flags_we_o     flag restore strobe
//   flags_o        flag restore value (0 outside the strobe)
//   redirect_o     fetch redirect strobe
//   redirect_pc_o  redirect target (0 outside the strobe)
//   irq_ack_o      one-hot acknowledge of the taken interrupt
//   cause_o        cause of the last taken trap
//   busy_o         sequencer not in IDLE
//   err_o          illegal request pulse
// ---------------------------------------------------------------------------
module trap_ctrl #(
   parameter int          NUM_IRQ   = 8,
   parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
   parameter int          VEC_SHIFT = 4
) (
   input  logic               clk_i,
   input  logic               arst_i,
   input  logic [31:0]        flags_i,
   input  logic [31:0]        pc_i,
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic               irq_en_i,
   input  logic               sw_trap_i,
   input  logic [6:0]         sw_trap_code_i,
   input  logic               iret_i,
   output logic               to_kernel_o,
   output logic               flags_we_o,
   output logic [31:0]        flags_o,
   output logic               redirect_o,
   output logic [31:0]        redirect_pc_o,
   output logic [NUM_IRQ-1:0] irq_ack_o,
   output logic [7:0]         cause_o,
   output logic               busy_o,
   output logic               err_o
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SAVE   = 2'd1;
   localparam logic [1:0] ST_ENTER  = 2'd2;
   localparam logic [1:0] ST_RETURN = 2'd3;

   logic [1:0]  r_state;
   logic [7:0]  r_cause_pend;   // cause chosen in IDLE, published during SAVE
   logic [7:0]  r_cause;
   logic [31:0] r_saved_flags;
   logic [31:0] r_saved_pc;
   logic        r_err;

   logic [1:0]  w_state_next;
   logic [7:0]  w_cause_next;
   logic        w_err_next;
   logic        w_irq_any;
   logic [4:0]  w_irq_idx;
   logic        w_kf;
   logic [31:0] w_vec_pc;

   assign w_kf = flags_i[0];

   // Lowest-index pending line: scanning downward lets the lowest set bit
   // be the last assignment.
   always_comb begin
      w_irq_any = 1'b0;
      w_irq_idx = 5'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (irq_i[i]) begin
            w_irq_any = 1'b1;
            w_irq_idx = 5'(i);
         end
      end
   end

   // Request arbitration only happens in IDLE; anything seen while busy is
   // ignored and the requester keeps it asserted.
   always_comb begin
      w_state_next = ST_IDLE;
      w_cause_next = r_cause_pend;
      w_err_next   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_kf) begin
               if (sw_trap_i) begin
                  w_state_next = ST_SAVE;
                  w_cause_next = {1'b0, sw_trap_code_i};
               end else if (irq_en_i && w_irq_any) begin
                  w_state_next = ST_SAVE;
                  w_cause_next = {3'b100, w_irq_idx};
               end
               // Returning from user mode is meaningless.
               w_err_next = iret_i;
            end else begin
               // No nesting: traps from kernel mode are illegal, IRQs wait.
               w_err_next = sw_trap_i;
               if (iret_i) begin
                  w_state_next = ST_RETURN;
               end
            end
         end
         ST_SAVE:  w_state_next = ST_ENTER;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_state       <= ST_IDLE;
         r_cause_pend  <= 8'd0;
         r_cause       <= 8'd0;
         r_saved_flags <= 32'd0;
         r_saved_pc    <= 32'd0;
         r_err         <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_err        <= w_err_next;
         r_cause_pend <= w_cause_next;
         if (r_state == ST_SAVE) begin
            r_saved_flags <= flags_i;
            r_saved_pc    <= pc_i;
            r_cause       <= r_cause_pend;
         end
      end
   end

   // Vector address wraps at 32 bits by construction.
   assign w_vec_pc = VEC_BASE + ({24'd0, r_cause} << VEC_SHIFT);

   assign to_kernel_o   = (r_state == ST_SAVE);
   assign flags_we_o    = (r_state == ST_RETURN);
   assign flags_o       = (r_state == ST_RETURN) ? {r_saved_flags[31:1], 1'b0} : 32'd0;
   assign redirect_o    = (r_state == ST_ENTER) || (r_state == ST_RETURN);
   assign redirect_pc_o = (r_state == ST_ENTER)  ? w_vec_pc :
                          (r_state == ST_RETURN) ? r_saved_pc : 32'd0;
   assign cause_o       = r_cause;
   assign busy_o        = (r_state != ST_IDLE);
   assign err_o         = r_err;

   // Ack follows the latched cause, so a line that dropped after SAVE is
   // still acknowledged.
   generate
      for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_ack
         assign irq_ack_o[gi] = (r_state == ST_ENTER) && r_cause[7] &&
                                (r_cause[4:0] == 5'(gi));
      end
   endgenerate

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap/interrupt sequencer that drives the kernel-mode flag register.
- Takes software traps and external interrupts from user mode, then pulses to_kernel for the flag register, saves the flags and PC, and redirects fetch to a vector.
- On return-from-trap it writes the saved flags back with the kernel bit cleared and redirects fetch to the saved PC.
- It sits between the core pipeline, the interrupt lines and the flag register. It reads the flag register's current value and drives that register's to_kernel and write inputs.

Parameters:
- NUM_IRQ, 8, number of external interrupt lines (1..32).
- VEC_BASE, 32'h0000_0100, base address of the trap vector table.
- VEC_SHIFT, 4, log2 of the vector entry stride in bytes.

Ports:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous active-high reset
- flags_i  in  32  current flag register value; bit 0 is KF (kernel mode)
- pc_i  in  32  PC of the instruction to resume after the trap
- irq_i  in  NUM_IRQ  level interrupt requests
- irq_en_i  in  1  global interrupt enable
- sw_trap_i  in  1  software trap request; level, held until redirect_o
- sw_trap_code_i  in  7  software trap code
- iret_i  in  1  return-from-trap request; level, held until redirect_o
- to_kernel_o  out  1  kernel-entry strobe to the flag register
- flags_we_o  out  1  flag restore strobe
- flags_o  out  32  flag restore value
- redirect_o  out  1  fetch redirect strobe
- redirect_pc_o  out  32  redirect target
- irq_ack_o  out  NUM_IRQ  one-hot acknowledge of the taken interrupt
- cause_o  out  8  cause of the last taken trap
- busy_o  out  1  sequencer not in IDLE
- err_o  out  1  illegal request pulse

Behaviour:
- Reset:
  - Reset is arst_i, asynchronous, active-high; clock is clk_i.
  - On reset: state=IDLE; saved_flags, saved_pc and cause_o are 0; every output is 0.
  - Reset asserted mid-sequence aborts the sequence: no ack, no redirect.
- All strobes are one-cycle pulses decoded from registered state (Moore).
- States: IDLE, SAVE, ENTER, RETURN.
- IDLE with KF=flags_i[0]=0 (user mode):
  - Priority is sw_trap_i > irq > iret_i.
  - If sw_trap_i: latch cause={1'b0, sw_trap_code_i} and go to SAVE.
  - Else if irq_en_i and irq_i != 0: take the lowest-index set line n, latch cause=8'h80|n, and go to SAVE.
  - A concurrent iret_i in user mode is illegal: err_o pulses for 1 cycle and the iret is otherwise ignored.
- IDLE with KF=1:
  - Interrupts are held pending and not taken.
  - sw_trap_i is illegal: err_o pulses each cycle it is high in IDLE.
  - iret_i → RETURN. If sw_trap_i is high in the same cycle, err_o also pulses.
- SAVE (1 cycle):
  - to_kernel_o=1, busy_o=1.
  - saved_flags←flags_i, saved_pc←pc_i, cause_o←cause.
  - Next state is ENTER. The flag register samples to_kernel at the end of SAVE, so KF=1 from the ENTER cycle onward.
- ENTER (1 cycle):
  - redirect_o=1, redirect_pc_o = VEC_BASE + (cause << VEC_SHIFT), 32-bit wrap.
  - irq_ack_o[n]=1 if the cause is an irq; otherwise irq_ack_o=0.
  - Next state is IDLE.
- RETURN (1 cycle):
  - flags_we_o=1, flags_o = {saved_flags[31:1], 1'b0}.
  - redirect_o=1, redirect_pc_o=saved_pc.
  - Next state is IDLE. The flag register loads bits [15:0] while in kernel mode, which clears KF.
- Latency: request high in IDLE at cycle T → to_kernel_o at T+1 → redirect_o at T+2 → IDLE at T+3. iret_i at T → flags_we_o and redirect_o at T+1.
- Requests seen while busy_o=1 are ignored. Requesters keep them asserted; an interrupt that is still high is re-evaluated in IDLE.
- Interrupt line n dropping after SAVE still gets acked. The ack only tells the source its request was taken.
- Nesting: not supported. Traps are taken only from user mode; saved state is a single level.
- redirect_pc_o and flags_o are 0 outside their strobe cycles. cause_o holds until the next SAVE.

Test Plan:
- Reset (KF=0), then sw_trap_i=1, code=7'h05, pc_i=32'h0000_2000 → to_kernel_o at T+1; redirect_o with redirect_pc_o=32'h0000_0150 at T+2; cause_o=8'h05; busy_o high for T+1..T+2.
- irq_i=8'b0010_0100, irq_en_i=1, KF=0 → line 2 taken; cause_o=8'h82; redirect_pc_o=32'h0000_0920; irq_ack_o=8'b0000_0100 in the redirect cycle only.
- Same-cycle sw_trap_i and irq_i[0] in user mode → software trap taken, irq_ack_o=0. Line 0 is taken only after KF returns to 0.
- After entry with saved flags 32'h0005_0000 (KF was 0), drive KF=1 and iret_i → at T+1 flags_we_o=1, flags_o=32'h0005_0000, redirect_pc_o=32'h0000_2000.
- KF=1 with sw_trap_i=1 → err_o=1 and no to_kernel_o. KF=0 with iret_i=1 → err_o=1 and no flags_we_o. irq_i=1 with KF=1 or irq_en_i=0 → no entry.
- Assert arst_i during SAVE → all outputs 0 immediately. After release, the sequencer is in IDLE with no redirect or ack; a request still held restarts entry from SAVE.
